fixed_div_seq: RTL

- Sequential, multi-cycle signed Q16.16 divider; the area-cheap counterpart to the combinational fixed-point `div` function in fixed_pkg.
- Computes quotient = lhs / rhs over 48/ITERS_PER_CYCLE cycles, using radix-2 restoring division on magnitudes.
- Valid/ready handshake on both sides.
- Used wherever a divide sits off the critical timing path (e.g. perspective and normalisation units).

---
 rtl/fixed_div_seq_pkg.sv | 19 +
 rtl/fixed_div_step.sv | 23 ++
 rtl/fixed_div_seq.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/fixed_div_seq_pkg.sv
// Shared Q16.16 widths, saturation constants and divider state type for fixed_div_seq.
package fixed_div_seq_pkg;

  localparam int unsigned TOTAL_WIDTH   = 32;
  localparam int unsigned DECIMAL_WIDTH = 16;
  localparam int unsigned DIV_NUM_WIDTH = TOTAL_WIDTH + DECIMAL_WIDTH;
  localparam int unsigned DIV_REM_WIDTH = TOTAL_WIDTH + 1;

  localparam logic [TOTAL_WIDTH-1:0] FIXED_MAX = 32'h7FFF_FFFF;
  localparam logic [TOTAL_WIDTH-1:0] FIXED_MIN = 32'h8000_0000;

  typedef enum logic [1:0] {DIV_IDLE, DIV_BUSY, DIV_DONE} div_state_t;

  // Unsigned magnitude; |-2^31| comes out as 2^31, which fits unsigned.
  function automatic logic [TOTAL_WIDTH-1:0] fixed_abs(input logic [TOTAL_WIDTH-1:0] v);
    return v[TOTAL_WIDTH-1] ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/fixed_div_step.sv
// One combinational radix-2 restoring division step: shift in a numerator bit, subtract if able.
module fixed_div_step
  import fixed_div_seq_pkg::*;
(
  input  logic [DIV_REM_WIDTH-1:0] rem_i,
  input  logic                     bit_i,
  input  logic [TOTAL_WIDTH-1:0]   den_i,
  output logic [DIV_REM_WIDTH-1:0] rem_o,
  output logic                     q_o
);

  logic [DIV_REM_WIDTH:0] shifted;
  logic [DIV_REM_WIDTH:0] den_ext;

  always_comb begin
    shifted = {rem_i, bit_i};
    den_ext = {2'b00, den_i};
    q_o     = (shifted >= den_ext);
    rem_o   = q_o ? (shifted[DIV_REM_WIDTH-1:0] - den_ext[DIV_REM_WIDTH-1:0])
                  : shifted[DIV_REM_WIDTH-1:0];
  end

endmodule

// File: rtl/fixed_div_seq.sv
// Multi-cycle signed Q16.16 divider (restoring, magnitude based, valid/ready on both sides).
// Define FIXED_DIV_ROUND_EN to round half away from zero instead of truncating.
module fixed_div_seq
  import fixed_div_seq_pkg::*;
#(
  parameter int unsigned ITERS_PER_CYCLE = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [TOTAL_WIDTH-1:0] in_lhs,
  input  logic [TOTAL_WIDTH-1:0] in_rhs,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [TOTAL_WIDTH-1:0] out_quotient,
  output logic                   out_div_by_zero,
  output logic                   busy
);

  localparam int unsigned Steps = DIV_NUM_WIDTH / ITERS_PER_CYCLE;
  localparam int unsigned CntW  = 6;

  div_state_t                 state_q, state_d;
  logic [DIV_NUM_WIDTH-1:0]   num_q, num_d;
  logic [TOTAL_WIDTH-1:0]     den_q, den_d;
  logic                       neg_q, neg_d;
  logic [DIV_REM_WIDTH-1:0]   rem_q, rem_d;
  logic [DIV_NUM_WIDTH-1:0]   quo_q, quo_d;
  logic [CntW-1:0]            cnt_q, cnt_d;
  logic [TOTAL_WIDTH-1:0]     result_q, result_d;
  logic                       dbz_q, dbz_d;

  logic [DIV_REM_WIDTH-1:0]   rem_chain [ITERS_PER_CYCLE+1];
  logic [ITERS_PER_CYCLE-1:0] q_bits;
  logic [DIV_NUM_WIDTH-1:0]   quo_next;
  logic                       round_up;
  logic [TOTAL_WIDTH-1:0]     mag_lo;

  assign rem_chain[0] = rem_q;

  // Step i consumes numerator bit 47-i this cycle, so the chain resolves bits MSB first.
  for (genvar i = 0; i < ITERS_PER_CYCLE; i++) begin : g_step
    fixed_div_step u_step (
      .rem_i (rem_chain[i]),
      .bit_i (num_q[DIV_NUM_WIDTH-1-i]),
      .den_i (den_q),
      .rem_o (rem_chain[i+1]),
      .q_o   (q_bits[ITERS_PER_CYCLE-1-i])
    );
  end

  always_comb begin
    quo_next = {quo_q[DIV_NUM_WIDTH-ITERS_PER_CYCLE-1:0], q_bits};
`ifdef FIXED_DIV_ROUND_EN
    round_up = ({rem_chain[ITERS_PER_CYCLE], 1'b0} >= {2'b00, den_q});
`else
    round_up = 1'b0;
`endif
    // Only the low 32 bits survive, so increment and negate can work on them alone.
    mag_lo = quo_next[TOTAL_WIDTH-1:0] + {{(TOTAL_WIDTH-1){1'b0}}, round_up};
  end

  always_comb begin
    state_d  = state_q;
    num_d    = num_q;
    den_d    = den_q;
    neg_d    = neg_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    dbz_d    = dbz_q;

    unique case (state_q)
      DIV_IDLE: begin
        if (in_valid) begin
          if (in_rhs == '0) begin
            result_d = in_lhs[TOTAL_WIDTH-1] ? FIXED_MIN : FIXED_MAX;
            dbz_d    = 1'b1;
            state_d  = DIV_DONE;
          end else begin
            num_d   = {fixed_abs(in_lhs), {DECIMAL_WIDTH{1'b0}}};
            den_d   = fixed_abs(in_rhs);
            neg_d   = in_lhs[TOTAL_WIDTH-1] ^ in_rhs[TOTAL_WIDTH-1];
            rem_d   = '0;
            quo_d   = '0;
            cnt_d   = CntW'(Steps);
            state_d = DIV_BUSY;
          end
        end
      end
      DIV_BUSY: begin
        num_d = num_q << ITERS_PER_CYCLE;
        rem_d = rem_chain[ITERS_PER_CYCLE];
        quo_d = quo_next;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CntW'(1)) begin
          result_d = neg_q ? (~mag_lo + 32'd1) : mag_lo;
          dbz_d    = 1'b0;
          state_d  = DIV_DONE;
        end
      end
      DIV_DONE: begin
        if (out_ready) begin
          state_d = DIV_IDLE;
        end
      end
      default: state_d = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= DIV_IDLE;
      num_q    <= '0;
      den_q    <= '0;
      neg_q    <= 1'b0;
      rem_q    <= '0;
      quo_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      num_q    <= num_d;
      den_q    <= den_d;
      neg_q    <= neg_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      dbz_q    <= dbz_d;
    end
  end

  assign in_ready        = (state_q == DIV_IDLE);
  assign busy            = (state_q == DIV_BUSY);
  assign out_valid       = (state_q == DIV_DONE);
  assign out_quotient    = result_q;
  assign out_div_by_zero = dbz_q;

endmodule
